// File: rtl/addr_nu_pipe_ft_if.sv
// Operand/result handshake bundle for addr_nu_pipe_ft.
// The master side is the producer/consumer pair. The slave side is the adder.
interface addr_nu_pipe_ft_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             err;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, sum, err);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, sum, err);
endinterface

// File: rtl/addr_nu_pipe_ft.sv
// Pipelined, replicated unsigned adder (sum = a + b) with compare-based fault flagging.
// Define ADDR_FT_TMR_VOTE_EN to add a third replica and take the bitwise majority as the sum.
module addr_nu_pipe_ft #(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    addr_nu_pipe_ft_if.slave     bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int STAGES = WIDTH / CHUNK;
`ifdef ADDR_FT_TMR_VOTE_EN
    localparam int NREP = 3;
`else
    localparam int NREP = 2;
`endif

    // Rank 0 holds captured operands; rank k holds the token after chunk k-1 is resolved.
    logic                                   advance;
    logic [STAGES:0]                        v_q;
    logic [NREP-1:0][STAGES:0][WIDTH-1:0]   a_q;
    logic [NREP-1:0][STAGES:0][WIDTH-1:0]   b_q;
    logic [NREP-1:0][STAGES:0][WIDTH-1:0]   s_q;
    logic [NREP-1:0][STAGES:0]              c_q;
    logic [NREP-1:0][STAGES:0][CHUNK:0]     part;
    logic [NREP-1:0][WIDTH:0]               r_sum;
    logic                                   count_evt;
    logic                                   unused_ops;

    assign advance       = !v_q[STAGES] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[STAGES];

    always_comb begin
        // NOTE: default the whole array first so no path leaves it unassigned (no latch).
        part = '0;
        for (int r = 0; r < NREP; r++) begin
            for (int k = 1; k <= STAGES; k++) begin
                part[r][k] = {1'b0, a_q[r][k-1][(k-1)*CHUNK +: CHUNK]}
                           + {1'b0, b_q[r][k-1][(k-1)*CHUNK +: CHUNK]}
                           + (CHUNK+1)'(c_q[r][k-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath ranks are reset as well, so sum reads 0 straight out of reset.
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
        end else if (advance) begin
            // NOTE: non-blocking, so each rank loads its predecessor's pre-edge value.
            v_q <= {v_q[STAGES-1:0], bus.in_valid};
            for (int r = 0; r < NREP; r++) begin
                if (bus.in_valid) begin
                    a_q[r][0] <= bus.a;
                    b_q[r][0] <= bus.b;
                    s_q[r][0] <= '0;
                    c_q[r][0] <= 1'b0;
                end
                for (int k = 1; k <= STAGES; k++) begin
                    if (v_q[k-1]) begin
                        a_q[r][k] <= a_q[r][k-1];
                        b_q[r][k] <= b_q[r][k-1];
                        s_q[r][k] <= s_q[r][k-1];
                        s_q[r][k][(k-1)*CHUNK +: CHUNK] <= part[r][k][CHUNK-1:0];
                        c_q[r][k] <= part[r][k][CHUNK];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < NREP; r++) begin : g_rep
        assign r_sum[r] = {c_q[r][STAGES], s_q[r][STAGES]};
    end

`ifdef ADDR_FT_TMR_VOTE_EN
    assign bus.sum = (r_sum[0] & r_sum[1]) | (r_sum[0] & r_sum[2]) | (r_sum[1] & r_sum[2]);
    assign bus.err = |((r_sum[0] ^ r_sum[1]) | (r_sum[1] ^ r_sum[2]));
`else
    assign bus.sum = r_sum[0];
    assign bus.err = |(r_sum[0] ^ r_sum[1]);
`endif

    // Clear takes effect first, then a same-cycle faulty transfer still counts.
    assign count_evt = v_q[STAGES] && bus.out_ready && bus.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= count_evt ? ERR_CNT_W'(1) : '0;
        end else if (count_evt && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Resolved low chunks and the last rank's operands are never read again.
    assign unused_ops = ^{a_q, b_q};
endmodule

// File: tb/tb_addr_nu_pipe_ft.sv
// Directed bench for addr_nu_pipe_ft (WIDTH=8, CHUNK=4, ERR_CNT_W=2).
// Covers reset, latency, stalls, replica fault injection, counter saturation/clear, mid-flight reset.
module tb_addr_nu_pipe_ft;
`ifdef ADDR_FT_TMR_VOTE_EN
    localparam int NREP = 3;
`else
    localparam int NREP = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic [1:0] err_cnt;
    int         checks = 0;
    int         errors = 0;

    logic [NREP*9-1:0] force_val;
    logic [7:0]        s_a[$];
    logic [7:0]        s_b[$];
    logic [8:0]        s_exp[$];

    addr_nu_pipe_ft_if #(.WIDTH(8)) bus ();

    addr_nu_pipe_ft #(.WIDTH(8), .CHUNK(4), .ERR_CNT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] ta, input logic [7:0] tb_, input logic [8:0] te);
        s_a.push_back(ta);
        s_b.push_back(tb_);
        s_exp.push_back(te);
    endtask

    // Drives the queued operands and checks results in order; rnd picks random ready/valid gaps.
    task automatic run_stream(input bit rnd);
        int         n = s_exp.size();
        int         got = 0;
        int         idx = 0;
        int         cyc = 0;
        bit         was_stall = 1'b0;
        bit         in_fire;
        logic [8:0] held = '0;
        while (got < n && cyc < 600) begin
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc inside {3, 4, 5});
            if (idx < n && (!rnd || $urandom_range(0, 4) != 0)) begin
                bus.in_valid = 1'b1;
                bus.a        = s_a[idx];
                bus.b        = s_b[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (was_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_sum", bus.sum, held);
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
            was_stall = bus.out_valid && !bus.out_ready;
            held      = bus.sum;
            if (bus.out_valid && bus.out_ready) begin
                check("stream_sum", bus.sum, s_exp[got]);
                check("stream_err", bus.err, 0);
                got++;
            end
            in_fire = bus.in_valid && bus.in_ready;
            tick();
            if (in_fire) idx++;
            cyc++;
        end
        check("stream_count", got, n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        s_a.delete();
        s_b.delete();
        s_exp.delete();
    endtask

    // One result with a corrupted replica sum held at the output until transfer.
    task automatic fault_one(input logic [7:0] fa, input logic [7:0] fb,
                             input bit clr, input logic [1:0] exp_cnt);
        logic [8:0] good;
        logic [8:0] bad;
        good = {1'b0, fa} + {1'b0, fb};
        bad  = good ^ 9'h001;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = fa;
        bus.b         = fb;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        check("fault_valid", bus.out_valid, 1);
`ifdef ADDR_FT_TMR_VOTE_EN
        force_val = {good, good, bad};
`else
        force_val = {bad, good};
`endif
        force dut.r_sum = force_val;
        #1;
        check("fault_err", bus.err, 1);
        check("fault_sum", bus.sum, good);
        err_clr       = clr;
        bus.out_ready = 1'b1;
        tick();
        release dut.r_sum;
        err_clr = 1'b0;
        check("fault_cnt", err_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        force_val     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // 0xFF + 0x01: carry ripples across the chunk boundary, two-edge latency.
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'h01;
        tick();
        bus.in_valid = 1'b0;
        check("lat_edge0", bus.out_valid, 0);
        tick();
        check("lat_edge1", bus.out_valid, 0);
        tick();
        check("lat_edge2", bus.out_valid, 1);
        check("carry_sum", bus.sum, 9'h100);
        check("carry_err", bus.err, 0);
        tick();
        check("drain", bus.out_valid, 0);

        // Back-to-back stream with three stalled cycles, plus the max-operand case.
        push(8'h10, 8'h20, 9'h030);
        push(8'h80, 8'h80, 9'h100);
        push(8'h0F, 8'h01, 9'h010);
        push(8'hFF, 8'hFF, 9'h1FE);
        run_stream(1'b0);

        // Replica disagreement and counter behaviour.
        check("cnt_before_fault", err_cnt, 0);
        fault_one(8'h03, 8'h04, 1'b0, 2'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_alone", err_cnt, 0);
        fault_one(8'h11, 8'h22, 1'b0, 2'd1);
        fault_one(8'hA0, 8'h0B, 1'b0, 2'd2);
        fault_one(8'h7F, 8'h01, 1'b0, 2'd3);
        fault_one(8'hC3, 8'h3C, 1'b0, 2'd3);
        fault_one(8'h55, 8'hAA, 1'b0, 2'd3);
        fault_one(8'h01, 8'h01, 1'b1, 2'd1);
        tick();
        check("clean_after_release", bus.err, 0);

        // Reset with two tokens in flight discards both.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h01;
        bus.b         = 8'h02;
        tick();
        bus.a = 8'h05;
        bus.b = 8'h06;
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        check("rst_flush", bus.out_valid, 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bus.out_valid;
        end
        check("no_stale", seen, 0);
        check("post_rst_ready", bus.in_ready, 1);
        check("post_rst_cnt", err_cnt, 0);

        // Random operands under random valid/ready gaps.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            push(ra, rb, {1'b0, ra} + {1'b0, rb});
        end
        run_stream(1'b1);
        check("final_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
